alu_muldiv_unit: RTL
====================

Name: alu_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the ALU operand-A mux.
- Takes operand A (the rs1-mux output) and operand B, plus a funct3 opcode.
- Multiply uses shift-add; divide uses restoring division. Each takes a fixed number of cycles.
- Result is returned over a valid/ready handshake to the writeback path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_req_valid  in  1  request present
- io_req_ready  out  1  unit can accept a request
- io_req_fn  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- io_alu_a  in  XLEN  operand A from the rs1 mux (io_to_alu_a)
- io_alu_b  in  XLEN  operand B
- io_kill  in  1  pipeline flush; abort the operation in flight
- io_resp_valid  out  1  result available
- io_resp_ready  in  1  consumer accepts the result
- io_resp_data  out  XLEN  result

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, and takes priority over every other input.
- Reset values: state=IDLE, io_req_ready=1, io_resp_valid=0, io_resp_data=0, internal counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - io_req_ready=1.
  - On req_valid && !kill at cycle T, capture fn, operand magnitudes and result-sign flags, then go to BUSY.
- Signedness per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - All other ops: unsigned.
- BUSY:
  - io_req_ready=0.
  - Performs one iteration per cycle for exactly XLEN cycles; counter runs 0..XLEN-1.
  - On the final iteration, apply sign correction and go to DONE.
- Latency: io_resp_valid rises at T+XLEN+1 (33 cycles for XLEN=32).
- DONE:
  - io_resp_valid=1 and io_req_ready=0.
  - io_resp_data stays stable until io_resp_ready=1; the next cycle is IDLE with resp_valid=0.
  - No back-to-back overlap: a new request can be accepted no earlier than the cycle after the handshake.
- Multiply:
  - Builds a 2*XLEN-bit product of the magnitudes, negated when the sign flag is set.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: quotient and remainder of the magnitudes.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero, for all four ops regardless of sign:
  - DIV and DIVU return all-ones.
  - REM and REMU return the original dividend.
- Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- Kill:
  - io_kill=1 in any state sends the FSM to IDLE next cycle with resp_valid=0, so no response is produced.
  - Kill in the same cycle as req_valid drops that request.
  - Kill in DONE discards the pending result even when resp_ready=1 in that cycle.
- Reset mid-BUSY or mid-DONE: same outcome as kill, plus io_resp_data is cleared to 0.
- io_resp_data is don't-care while resp_valid=0, but holds its last value (not X).

Optional Feature:
- Macro: ALU_MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow divides skip BUSY.
  - The FSM goes IDLE→DONE at the accept cycle with the special result.
  - io_resp_valid rises at T+1.
- Undefined: these cases take the full XLEN+1 latency and give identical result values.

Decomposition:
- Package alu_muldiv_pkg holds:
  - XLEN default and the funct3 localparams (FN_MUL..FN_REMU).
  - The FSM state encoding.
  - The helper function is_div(fn)=fn[2].
- One sub-module, alu_muldiv_negate:
  - Combinational conditional two's-complement, parameterised width.
  - Instantiated for operand absolute value (XLEN) and result fixup (2*XLEN).

Test Plan:
- MUL/MULH directed: A=0xFFFFFFFF (-1), B=0x00000002.
  - MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001, MULHSU → 0xFFFFFFFF.
  - resp_valid at exactly T+33.
- DIV/REM signs: A=-7 (0xFFFFFFF9), B=2.
  - DIV → 0xFFFFFFFD (-3), REM → 0xFFFFFFFF (-1).
  - DIVU → 0x7FFFFFFC, REMU → 1.
- Boundaries:
  - A=0x12345678, B=0: DIV → 0xFFFFFFFF, REMU → 0x12345678.
  - A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
  - Latency is T+1 with ALU_MULDIV_EARLY_OUT_EN defined, T+33 without.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid.
  - resp_data and resp_valid stay stable, req_ready=0 throughout.
  - After the handshake, req_ready=1 and a new request is accepted the following cycle.
- Kill and reset:
  - Assert kill at BUSY cycle 10: no resp_valid ever appears, req_ready=1 next cycle.
  - A new MUL 3*5 then returns 15.
  - Repeat with reset at cycle 10: same recovery, and resp_data reads 0.
- Randomised check: 1000 random (fn, A, B) triples against a reference model, with random resp_ready gaps; all results match.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// default width, funct3 encodings, FSM state encoding and op-class helper.
package alu_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] fn);
    return fn[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_negate.sv
// Conditional two's-complement negation.
//   value   : input operand (W bits)
//   neg     : 1 = return -value, 0 = pass through
//   result  : output (W bits)
module alu_muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// One iteration per cycle for XLEN cycles; result returned via valid/ready.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   io_req_valid/io_req_ready    : request handshake
//   io_req_fn                    : funct3 opcode (MUL..REMU)
//   io_alu_a, io_alu_b           : operands (A from the rs1 mux)
//   io_kill                      : flush, abandons any operation in flight
//   io_resp_valid/io_resp_ready  : response handshake
//   io_resp_data                 : result
// Build option: ALU_MULDIV_EARLY_OUT_EN lets divide-by-zero and signed
// overflow divides go straight to DONE with the special result.
module alu_muldiv_unit
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [2:0]      io_req_fn,
  input  logic [XLEN-1:0] io_alu_a,
  input  logic [XLEN-1:0] io_alu_b,
  input  logic            io_kill,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic [XLEN-1:0] io_resp_data
);

  localparam int CW = $clog2(XLEN);

`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif

  state_t state, state_nxt;

  logic [2:0]      fn_q;
  logic [XLEN-1:0] acc_hi, acc_lo, mb;
  logic            res_neg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] resp_data;

  // ---- request decode -------------------------------------------------
  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, fast, accept, neg;
  logic [XLEN-1:0] a_abs, b_abs, special;

  assign a_sgn  = (io_req_fn == FN_MULH) || (io_req_fn == FN_MULHSU) ||
                  (io_req_fn == FN_DIV)  || (io_req_fn == FN_REM);
  assign b_sgn  = (io_req_fn == FN_MULH) || (io_req_fn == FN_DIV) ||
                  (io_req_fn == FN_REM);
  assign a_neg  = a_sgn && io_alu_a[XLEN-1];
  assign b_neg  = b_sgn && io_alu_b[XLEN-1];
  assign b_zero = (io_alu_b == '0);
  assign ovf    = is_div(io_req_fn) && b_sgn &&
                  (io_alu_a == {1'b1, {(XLEN-1){1'b0}}}) && (io_alu_b == '1);
  assign fast   = is_div(io_req_fn) && (b_zero || ovf);
  assign accept = (state == IDLE) && io_req_valid && !io_kill;

  // One sign flag covers every op: product sign, quotient sign (suppressed
  // for a zero divisor so the all-ones quotient survives), or the
  // dividend's sign for remainders. A zero divisor leaves |A| in the
  // remainder, so the dividend's sign restores the original A.
  always_comb begin
    neg = a_neg ^ b_neg;
    if (is_div(io_req_fn)) begin
      if (io_req_fn[1]) neg = a_neg;
      else              neg = (a_neg ^ b_neg) && !b_zero;
    end
  end

  // Early-out results: bit 1 of funct3 selects remainder over quotient.
  assign special = b_zero ? (io_req_fn[1] ? io_alu_a : '1)
                          : (io_req_fn[1] ? '0 : io_alu_a);

  alu_muldiv_negate #(.W(XLEN)) u_abs_a (.value(io_alu_a), .neg(a_neg), .result(a_abs));
  alu_muldiv_negate #(.W(XLEN)) u_abs_b (.value(io_alu_b), .neg(b_neg), .result(b_abs));

  // ---- iteration step -------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   hi_nxt, lo_nxt, result;
  logic [2*XLEN-1:0] fix_in, fix_out;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mb};

  always_comb begin
    hi_nxt = '0;
    lo_nxt = '0;
    if (is_div(fn_q)) begin
      // Restoring step: a borrow means the trial subtract is discarded.
      hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      {hi_nxt, lo_nxt} = {mul_sum, acc_lo[XLEN-1:1]};
    end
  end

  assign fix_in = is_div(fn_q) ? {{XLEN{1'b0}}, (fn_q[1] ? hi_nxt : lo_nxt)}
                               : {hi_nxt, lo_nxt};

  alu_muldiv_negate #(.W(2*XLEN)) u_fix (.value(fix_in), .neg(res_neg), .result(fix_out));

  assign result = ((fn_q == FN_MUL) || is_div(fn_q)) ? fix_out[XLEN-1:0]
                                                    : fix_out[2*XLEN-1:XLEN];

  // ---- FSM ------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (EARLY_OUT && fast) ? DONE : BUSY;
      BUSY: if (cnt == CW'(XLEN-1)) state_nxt = DONE;
      DONE: if (io_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (io_kill) state_nxt = IDLE;
  end

  // ---- datapath -------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fn_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mb        <= '0;
      res_neg   <= 1'b0;
      cnt       <= '0;
      resp_data <= '0;
    end else if (accept) begin
      fn_q    <= io_req_fn;
      acc_hi  <= '0;
      acc_lo  <= a_abs;
      mb      <= b_abs;
      res_neg <= neg;
      cnt     <= '0;
      if (EARLY_OUT && fast) resp_data <= special;
    end else if (state == BUSY) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(XLEN-1)) resp_data <= result;
    end
  end

  assign io_req_ready  = (state == IDLE);
  assign io_resp_valid = (state == DONE);
  assign io_resp_data  = resp_data;

endmodule
